sram_sdport_syn: RTL and testbench

- Parametrised simple-dual-port synchronous SRAM: one write port and one independent read port on a single clock.
- Adds byte-lane write enables, a selectable read latency of 1 or 2 cycles, a read-valid strobe, and a defined read-during-write mode with a collision flag.
- Successor to the 64 KB single-port byte SRAM.
- Used as a scratchpad/line buffer between a producer and a consumer that access memory in the same cycle.

---
 rtl/sram_pkg.sv | 12 +
 rtl/sram_sdport_syn_if.sv | 31 +++
 rtl/sram_out_pipe.sv | 39 +++
 rtl/sram_sdport_syn.sv | 106 ++++++++++
 tb/tb_sram_sdport_syn.sv | 203 ++++++++++++++++++++
 5 files changed

// File: rtl/sram_pkg.sv
// Shared constants and helpers for the simple-dual-port SRAM family.
package sram_pkg;

  localparam int unsigned BYTE_W          = 8;
  localparam int unsigned RDW_READ_FIRST  = 0;
  localparam int unsigned RDW_WRITE_FIRST = 1;

  function automatic int unsigned lane_count(input int unsigned data_w);
    return data_w / BYTE_W;
  endfunction

endpackage

// File: rtl/sram_sdport_syn_if.sv
// Write/read port bundle of the simple-dual-port SRAM; master drives requests, slave returns data.
interface sram_sdport_syn_if
  import sram_pkg::*;
#(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 10
);

  localparam int unsigned Lanes = lane_count(DATA_W);

  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [Lanes-1:0]  wr_be;
  logic [DATA_W-1:0] wr_data;
  logic              rd_en;
  logic [ADDR_W-1:0] rd_addr;
  logic [DATA_W-1:0] rd_data;
  logic              rd_valid;
  logic              collision;

  modport master (
    output wr_en, wr_addr, wr_be, wr_data, rd_en, rd_addr,
    input  rd_data, rd_valid, collision
  );

  modport slave (
    input  wr_en, wr_addr, wr_be, wr_data, rd_en, rd_addr,
    output rd_data, rd_valid, collision
  );

endinterface

// File: rtl/sram_out_pipe.sv
// Optional output register stage carrying {data, valid, collision}; data holds between valid results.
module sram_out_pipe #(
  parameter int unsigned DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] data_i,
  input  logic              valid_i,
  input  logic              coll_i,
  output logic [DATA_W-1:0] data_o,
  output logic              valid_o,
  output logic              coll_o
);

  logic [DATA_W-1:0] data_q, data_d;
  logic              valid_q, coll_q;

  always_comb begin
    data_d = data_q;
    if (valid_i) data_d = data_i;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_q  <= '0;
      valid_q <= 1'b0;
      coll_q  <= 1'b0;
    end else begin
      data_q  <= data_d;
      valid_q <= valid_i;
      coll_q  <= coll_i;
    end
  end

  assign data_o  = data_q;
  assign valid_o = valid_q;
  assign coll_o  = coll_q;

endmodule

// File: rtl/sram_sdport_syn.sv
// Simple-dual-port synchronous SRAM with byte enables, 1/2-cycle read latency and
// configurable read-during-write behaviour with a collision flag.
module sram_sdport_syn
  import sram_pkg::*;
#(
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned ADDR_W   = 10,
  parameter int unsigned READ_LAT = 1,
  parameter int unsigned RDW_MODE = RDW_READ_FIRST
) (
  input  logic               clk,
  input  logic               rst_n,
  sram_sdport_syn_if.slave   bus
);

  localparam int unsigned Lanes = lane_count(DATA_W);
  localparam int unsigned Depth = 2 ** ADDR_W;

  if (READ_LAT != 1 && READ_LAT != 2) begin : g_bad_read_lat
    $error("sram_sdport_syn: READ_LAT must be 1 or 2");
  end
  if ((DATA_W % BYTE_W) != 0 || DATA_W == 0) begin : g_bad_data_w
    $error("sram_sdport_syn: DATA_W must be a nonzero multiple of 8");
  end

  // Array is deliberately outside the reset domain so contents survive rst_n.
  logic [DATA_W-1:0] mem_q [Depth];

  always_ff @(posedge clk) begin
    if (bus.wr_en) begin
      for (int i = 0; i < int'(Lanes); i++) begin
        if (bus.wr_be[i]) mem_q[bus.wr_addr][i*BYTE_W +: BYTE_W] <= bus.wr_data[i*BYTE_W +: BYTE_W];
      end
    end
  end

  logic [DATA_W-1:0] rd_word;
  logic [DATA_W-1:0] fwd_word;
  logic              addr_match;
  logic              rdw_hit;

  assign rd_word    = mem_q[bus.rd_addr];
  assign addr_match = bus.wr_en && (bus.rd_addr == bus.wr_addr);
  assign rdw_hit    = bus.rd_en && addr_match && (|bus.wr_be);

  // Write-first forwards only the lanes being written; other lanes come from the array.
  always_comb begin
    fwd_word = rd_word;
    if (RDW_MODE == RDW_WRITE_FIRST && addr_match) begin
      for (int i = 0; i < int'(Lanes); i++) begin
        if (bus.wr_be[i]) fwd_word[i*BYTE_W +: BYTE_W] = bus.wr_data[i*BYTE_W +: BYTE_W];
      end
    end
  end

  logic [DATA_W-1:0] s1_data_q, s1_data_d;
  logic              s1_valid_q, s1_valid_d;
  logic              s1_coll_q, s1_coll_d;

  always_comb begin
    s1_data_d  = s1_data_q;
    s1_valid_d = bus.rd_en;
    s1_coll_d  = rdw_hit;
    if (bus.rd_en) s1_data_d = fwd_word;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_data_q  <= '0;
      s1_valid_q <= 1'b0;
      s1_coll_q  <= 1'b0;
    end else begin
      s1_data_q  <= s1_data_d;
      s1_valid_q <= s1_valid_d;
      s1_coll_q  <= s1_coll_d;
    end
  end

  logic [DATA_W-1:0] out_data;
  logic              out_valid;
  logic              out_coll;

  if (READ_LAT == 2) begin : g_lat2
    sram_out_pipe #(
      .DATA_W (DATA_W)
    ) u_out_pipe (
      .clk     (clk),
      .rst_n   (rst_n),
      .data_i  (s1_data_q),
      .valid_i (s1_valid_q),
      .coll_i  (s1_coll_q),
      .data_o  (out_data),
      .valid_o (out_valid),
      .coll_o  (out_coll)
    );
  end else begin : g_lat1
    assign out_data  = s1_data_q;
    assign out_valid = s1_valid_q;
    assign out_coll  = s1_coll_q;
  end

  assign bus.rd_data   = out_data;
  assign bus.rd_valid  = out_valid;
  assign bus.collision = out_coll;

endmodule

// File: tb/tb_sram_sdport_syn.sv
// Directed bench for sram_sdport_syn: three configurations share one stimulus stream.
module tb_sram_sdport_syn;

  localparam int unsigned DW = 32;
  localparam int unsigned AW = 10;

  logic          clk;
  logic          rst_n;
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [3:0]    wr_be;
  logic [DW-1:0] wr_data;
  logic          rd_en;
  logic [AW-1:0] rd_addr;

  int n_checks;
  int n_errors;

  sram_sdport_syn_if #(.DATA_W(DW), .ADDR_W(AW)) if0 ();
  sram_sdport_syn_if #(.DATA_W(DW), .ADDR_W(AW)) if1 ();
  sram_sdport_syn_if #(.DATA_W(DW), .ADDR_W(AW)) if2 ();

  assign if0.wr_en = wr_en;  assign if0.wr_addr = wr_addr;  assign if0.wr_be = wr_be;
  assign if0.wr_data = wr_data;  assign if0.rd_en = rd_en;  assign if0.rd_addr = rd_addr;
  assign if1.wr_en = wr_en;  assign if1.wr_addr = wr_addr;  assign if1.wr_be = wr_be;
  assign if1.wr_data = wr_data;  assign if1.rd_en = rd_en;  assign if1.rd_addr = rd_addr;
  assign if2.wr_en = wr_en;  assign if2.wr_addr = wr_addr;  assign if2.wr_be = wr_be;
  assign if2.wr_data = wr_data;  assign if2.rd_en = rd_en;  assign if2.rd_addr = rd_addr;

  // d0: default (lat 1, read-first); d1: lat 2, read-first; d2: lat 1, write-first
  sram_sdport_syn #(.DATA_W(DW), .ADDR_W(AW)) u_d0 (.clk(clk), .rst_n(rst_n), .bus(if0));
  sram_sdport_syn #(.DATA_W(DW), .ADDR_W(AW), .READ_LAT(2), .RDW_MODE(0)) u_d1 (
    .clk(clk), .rst_n(rst_n), .bus(if1));
  sram_sdport_syn #(.DATA_W(DW), .ADDR_W(AW), .READ_LAT(1), .RDW_MODE(1)) u_d2 (
    .clk(clk), .rst_n(rst_n), .bus(if2));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic          we;
    logic [AW-1:0] wa;
    logic [3:0]    be;
    logic [DW-1:0] wd;
    logic          re;
    logic [AW-1:0] ra;
    logic          ev;
    logic [DW-1:0] ed0;
    logic          ec0;
    logic [DW-1:0] ed2;
    logic          ec2;
  } vec_t;

  localparam int NVec = 20;
  vec_t vecs[NVec];

  function automatic vec_t mk(input logic we, input logic [AW-1:0] wa, input logic [3:0] be,
                              input logic [DW-1:0] wd, input logic re, input logic [AW-1:0] ra,
                              input logic ev, input logic [DW-1:0] ed0, input logic ec0,
                              input logic [DW-1:0] ed2, input logic ec2);
    vec_t v;
    v.we = we; v.wa = wa; v.be = be; v.wd = wd; v.re = re; v.ra = ra;
    v.ev = ev; v.ed0 = ed0; v.ec0 = ec0; v.ed2 = ed2; v.ec2 = ec2;
    return v;
  endfunction

  task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic drive(input logic we, input logic [AW-1:0] wa, input logic [3:0] be,
                       input logic [DW-1:0] wd, input logic re, input logic [AW-1:0] ra);
    wr_en = we; wr_addr = wa; wr_be = be; wr_data = wd; rd_en = re; rd_addr = ra;
  endtask

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  logic [DW-1:0] prev_d;
  logic          prev_v;
  logic          prev_c;

  initial begin
    n_checks = 0;
    n_errors = 0;
    rst_n    = 1'b0;
    drive(1'b0, '0, 4'h0, '0, 1'b0, '0);

    vecs[0]  = mk(1, 10'h005, 4'hF, 32'hDEADBEEF, 0, 10'h000, 0, 32'h0, 0, 32'h0, 0);
    vecs[1]  = mk(1, 10'h010, 4'hF, 32'h11223344, 0, 10'h000, 0, 32'h0, 0, 32'h0, 0);
    vecs[2]  = mk(1, 10'h010, 4'h5, 32'hAABBCCDD, 0, 10'h000, 0, 32'h0, 0, 32'h0, 0);
    vecs[3]  = mk(0, 10'h000, 4'h0, 32'h0, 1, 10'h010, 1, 32'h11BB33DD, 0, 32'h11BB33DD, 0);
    vecs[4]  = mk(1, 10'h020, 4'hF, 32'h01020304, 1, 10'h005, 1, 32'hDEADBEEF, 0,
                  32'hDEADBEEF, 0);
    vecs[5]  = mk(1, 10'h000, 4'hF, 32'hA0A0A000, 0, 10'h000, 0, 32'hDEADBEEF, 0,
                  32'hDEADBEEF, 0);
    vecs[6]  = mk(1, 10'h001, 4'hF, 32'hA0A0A001, 0, 10'h000, 0, 32'hDEADBEEF, 0,
                  32'hDEADBEEF, 0);
    vecs[7]  = mk(1, 10'h002, 4'hF, 32'hA0A0A002, 0, 10'h000, 0, 32'hDEADBEEF, 0,
                  32'hDEADBEEF, 0);
    vecs[8]  = mk(1, 10'h003, 4'hF, 32'hA0A0A003, 0, 10'h000, 0, 32'hDEADBEEF, 0,
                  32'hDEADBEEF, 0);
    vecs[9]  = mk(0, 10'h000, 4'h0, 32'h0, 1, 10'h000, 1, 32'hA0A0A000, 0, 32'hA0A0A000, 0);
    vecs[10] = mk(0, 10'h000, 4'h0, 32'h0, 1, 10'h001, 1, 32'hA0A0A001, 0, 32'hA0A0A001, 0);
    vecs[11] = mk(0, 10'h000, 4'h0, 32'h0, 1, 10'h002, 1, 32'hA0A0A002, 0, 32'hA0A0A002, 0);
    vecs[12] = mk(0, 10'h000, 4'h0, 32'h0, 1, 10'h003, 1, 32'hA0A0A003, 0, 32'hA0A0A003, 0);
    vecs[13] = mk(0, 10'h000, 4'h0, 32'h0, 0, 10'h000, 0, 32'hA0A0A003, 0, 32'hA0A0A003, 0);
    vecs[14] = mk(1, 10'h020, 4'hC, 32'hF0F0F0F0, 1, 10'h020, 1, 32'h01020304, 1,
                  32'hF0F00304, 1);
    vecs[15] = mk(0, 10'h000, 4'h0, 32'h0, 1, 10'h020, 1, 32'hF0F00304, 0, 32'hF0F00304, 0);
    vecs[16] = mk(1, 10'h020, 4'h0, 32'h55555555, 1, 10'h020, 1, 32'hF0F00304, 0,
                  32'hF0F00304, 0);
    vecs[17] = mk(0, 10'h020, 4'hF, 32'h12345678, 1, 10'h020, 1, 32'hF0F00304, 0,
                  32'hF0F00304, 0);
    vecs[18] = mk(0, 10'h000, 4'h0, 32'h0, 1, 10'h020, 1, 32'hF0F00304, 0, 32'hF0F00304, 0);
    vecs[19] = mk(0, 10'h000, 4'h0, 32'h0, 0, 10'h000, 0, 32'hF0F00304, 0, 32'hF0F00304, 0);

    cycle();
    cycle();
    check("reset_d0_data", if0.rd_data, 32'h0);
    check("reset_d0_valid", {31'b0, if0.rd_valid}, 32'h0);
    check("reset_d1_valid", {31'b0, if1.rd_valid}, 32'h0);
    rst_n = 1'b1;

    // Lat-2 device lags the lat-1 expectations by exactly one row.
    prev_d = '0; prev_v = 1'b0; prev_c = 1'b0;
    for (int i = 0; i < NVec; i++) begin
      drive(vecs[i].we, vecs[i].wa, vecs[i].be, vecs[i].wd, vecs[i].re, vecs[i].ra);
      cycle();
      check($sformatf("v%0d_d0_data", i), if0.rd_data, vecs[i].ed0);
      check($sformatf("v%0d_d0_valid", i), {31'b0, if0.rd_valid}, {31'b0, vecs[i].ev});
      check($sformatf("v%0d_d0_coll", i), {31'b0, if0.collision}, {31'b0, vecs[i].ec0});
      check($sformatf("v%0d_d2_data", i), if2.rd_data, vecs[i].ed2);
      check($sformatf("v%0d_d2_valid", i), {31'b0, if2.rd_valid}, {31'b0, vecs[i].ev});
      check($sformatf("v%0d_d2_coll", i), {31'b0, if2.collision}, {31'b0, vecs[i].ec2});
      check($sformatf("v%0d_d1_data", i), if1.rd_data, prev_d);
      check($sformatf("v%0d_d1_valid", i), {31'b0, if1.rd_valid}, {31'b0, prev_v});
      check($sformatf("v%0d_d1_coll", i), {31'b0, if1.collision}, {31'b0, prev_c});
      prev_d = vecs[i].ed0; prev_v = vecs[i].ev; prev_c = vecs[i].ec0;
    end

    // Asynchronous reset mid-run clears outputs immediately, array survives.
    drive(1'b0, '0, 4'h0, '0, 1'b1, 10'h005);
    cycle();
    check("pre_rst_d0_data", if0.rd_data, 32'hDEADBEEF);
    drive(1'b0, '0, 4'h0, '0, 1'b0, '0);
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_d0_data", if0.rd_data, 32'h0);
    check("async_rst_d0_valid", {31'b0, if0.rd_valid}, 32'h0);
    check("async_rst_d1_data", if1.rd_data, 32'h0);
    check("async_rst_d2_data", if2.rd_data, 32'h0);
    // A write while reset is held still lands in the array.
    drive(1'b1, 10'h040, 4'hF, 32'h0BADF00D, 1'b0, '0);
    cycle();
    check("in_rst_d1_valid", {31'b0, if1.rd_valid}, 32'h0);
    rst_n = 1'b1;
    drive(1'b0, '0, 4'h0, '0, 1'b1, 10'h005);
    cycle();
    check("retain_d0_data", if0.rd_data, 32'hDEADBEEF);
    check("retain_d0_valid", {31'b0, if0.rd_valid}, 32'h1);
    check("retain_d1_valid", {31'b0, if1.rd_valid}, 32'h0);
    drive(1'b0, '0, 4'h0, '0, 1'b1, 10'h040);
    cycle();
    check("rst_write_d0_data", if0.rd_data, 32'h0BADF00D);
    check("retain_d1_data", if1.rd_data, 32'hDEADBEEF);
    check("retain_d1_valid2", {31'b0, if1.rd_valid}, 32'h1);
    drive(1'b0, '0, 4'h0, '0, 1'b0, '0);
    cycle();
    check("rst_write_d1_data", if1.rd_data, 32'h0BADF00D);

    // Lat-2 read in flight is dropped by a reset pulse in the following cycle.
    drive(1'b0, '0, 4'h0, '0, 1'b1, 10'h010);
    cycle();
    drive(1'b0, '0, 4'h0, '0, 1'b0, '0);
    #2 rst_n = 1'b0;
    #2 rst_n = 1'b1;
    cycle();
    check("drop_d1_valid", {31'b0, if1.rd_valid}, 32'h0);
    check("drop_d1_data", if1.rd_data, 32'h0);
    check("drop_d0_valid", {31'b0, if0.rd_valid}, 32'h0);
    drive(1'b0, '0, 4'h0, '0, 1'b1, 10'h010);
    cycle();
    check("after_drop_d1_n1", {31'b0, if1.rd_valid}, 32'h0);
    drive(1'b0, '0, 4'h0, '0, 1'b0, '0);
    cycle();
    check("after_drop_d1_valid", {31'b0, if1.rd_valid}, 32'h1);
    check("after_drop_d1_data", if1.rd_data, 32'h11BB33DD);
    cycle();
    check("after_drop_d1_pulse", {31'b0, if1.rd_valid}, 32'h0);
    check("after_drop_d1_hold", if1.rd_data, 32'h11BB33DD);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
